// File: rtl/serie_paralelo_rx_pkg.sv
// -----------------------------------------------------------------------------
// serie_paralelo_rx_pkg
// Shared PHY definitions used by both the serializer and the deserializer:
//   - IDLE_CHAR_DEFAULT : comma/idle byte sent whenever no payload is pending
//   - BC_NEEDED_DEFAULT : consecutive aligned idle bytes required to lock
//   - rx_state_e        : receiver alignment FSM encoding
// -----------------------------------------------------------------------------
package serie_paralelo_rx_pkg;

  localparam logic [7:0] IDLE_CHAR_DEFAULT = 8'hBC;
  localparam int         BC_NEEDED_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,  // bit-level hunt for the first idle byte
    ST_ALIGN  = 2'd1,  // byte framing assumed, counting aligned idle bytes
    ST_ACTIVE = 2'd2   // locked; decoding payload bytes
  } rx_state_e;

endpackage

// File: rtl/serie_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serie_paralelo_rx
// Serial-to-parallel receiver with comma-based byte alignment. Bits arrive MSB
// first, one per clk_8f. The FSM hunts bit by bit for IDLE_CHAR, then requires
// BC_NEEDED consecutive aligned idle bytes before declaring lock. Once locked,
// every byte boundary pulses byte_strobe; non-idle bytes are also presented
// on data_out with a one-cycle valid_out. Lock is held until reset.
//
// Ports
//   clk_8f      in   bit clock, rising edge
//   reset       in   synchronous, active-low
//   data_in     in   serial bit stream, MSB of each byte first
//   data_out    out  [7:0] last received payload (non-idle) byte
//   valid_out   out  one-cycle pulse when data_out holds a new payload byte
//   byte_strobe out  one-cycle pulse on every byte boundary while locked
//   active      out  high while locked
// -----------------------------------------------------------------------------
module serie_paralelo_rx
  import serie_paralelo_rx_pkg::*;
#(
  parameter int         BC_NEEDED = BC_NEEDED_DEFAULT,
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEFAULT
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int BCW = $clog2(BC_NEEDED + 1);
  localparam logic [BCW-1:0] BC_FULL     = BCW'(BC_NEEDED);
  localparam logic [BCW:0]   BC_FULL_EXT = (BCW+1)'(BC_NEEDED);

  // Only the seven most recent bits need storing: the eighth bit of the
  // candidate byte is always the live data_in.
  logic [6:0]     sr_q, sr_d;
  rx_state_e      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] bc_cnt_q, bc_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           strobe_q, strobe_d;
  logic           active_q, active_d;

  logic [7:0]     cand_s;
  logic           boundary_s;
  logic [BCW:0]   bc_inc_s;

  // Next-state, counter and output computation
  always_comb begin
    cand_s     = {sr_q, data_in};
    boundary_s = (bit_cnt_q == 3'd7);
    bc_inc_s   = {1'b0, bc_cnt_q} + (BCW+1)'(1);

    sr_d      = cand_s[6:0];
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    strobe_d  = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        // Framing starts fresh on the cycle after the idle byte completes
        bit_cnt_d = 3'd0;
        if (cand_s == IDLE_CHAR) begin
          bc_cnt_d = BCW'(1);
          if (BC_FULL <= BCW'(1)) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_ALIGN;
          end
        end else begin
          bc_cnt_d = '0;
          state_d  = ST_SEARCH;
        end
      end

      ST_ALIGN: begin
        if (boundary_s) begin
          if (cand_s == IDLE_CHAR) begin
            if (bc_inc_s >= BC_FULL_EXT) begin
              bc_cnt_d = BC_FULL;
              state_d  = ST_ACTIVE;
            end else begin
              bc_cnt_d = bc_inc_s[BCW-1:0];
              state_d  = ST_ALIGN;
            end
          end else begin
            // Any non-idle aligned byte voids all credit gathered so far
            bc_cnt_d = '0;
            state_d  = ST_SEARCH;
          end
        end else begin
          state_d = ST_ALIGN;
        end
      end

      ST_ACTIVE: begin
        if (boundary_s) begin
          strobe_d = 1'b1;
          if (cand_s != IDLE_CHAR) begin
            data_d  = cand_s;
            valid_d = 1'b1;
          end else begin
            data_d  = data_q;
            valid_d = 1'b0;
          end
        end else begin
          strobe_d = 1'b0;
        end
      end

      default: begin
        state_d   = ST_SEARCH;
        bc_cnt_d  = '0;
        bit_cnt_d = 3'd0;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      sr_q      <= 7'd0;
      state_q   <= ST_SEARCH;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serie_paralelo_rx
// Self-checking bench for serie_paralelo_rx. A behavioural reference model
// tracks the last eight received bits, the lock mode and the cycle at which
// byte framing was anchored; byte boundaries are found by modular distance
// from that anchor. DUT outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serie_paralelo_rx;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk_8f  = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_hist, m_mode, m_cycle, m_anchor, m_bcs;
  logic [7:0] m_data;
  logic       m_valid, m_strobe, m_active;

  logic stim[$];

  serie_paralelo_rx dut (
    .clk_8f      (clk_8f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk_8f = ~clk_8f;

  function automatic logic [10:0] dut_vec();
    return {data_out, valid_out, byte_strobe, active};
  endfunction

  function automatic logic [10:0] mdl_vec();
    return {m_data, m_valid, m_strobe, m_active};
  endfunction

  // mode: 0 = hunting, 1 = counting idles, 2 = locked
  task automatic model_step(input logic b, input logic r);
    m_valid  = 1'b0;
    m_strobe = 1'b0;
    if (!r) begin
      m_hist = 0; m_mode = 0; m_cycle = 0; m_anchor = 0; m_bcs = 0;
      m_data = 8'h00;
    end else begin
      m_cycle++;
      m_hist = ((m_hist << 1) | int'(b)) & 255;
      if (m_mode == 0) begin
        if (m_hist == int'(BC)) begin
          m_mode = 1; m_anchor = m_cycle; m_bcs = 1;
        end
      end else if ((m_cycle - m_anchor) % 8 == 0) begin
        if (m_mode == 1) begin
          if (m_hist == int'(BC)) begin
            m_bcs++;
            if (m_bcs >= 4) m_mode = 2;
          end else begin
            m_mode = 0; m_bcs = 0;
          end
        end else begin
          m_strobe = 1'b1;
          if (m_hist != int'(BC)) begin
            m_valid = 1'b1;
            m_data  = 8'(m_hist);
          end
        end
      end
    end
    m_active = (m_mode == 2);
  endtask

  task automatic drive(input logic b, input logic r);
    data_in = b;
    reset   = r;
    @(posedge clk_8f);
    model_step(b, r);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) stim.push_back(v[k]);
  endtask

  function automatic logic [7:0] rand_payload();
    logic [7:0] r;
    do r = 8'($urandom); while (r == BC);
    return r;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'b0);
      n_cmp++;
      if (dut_vec() !== 11'h000 || mdl_vec() !== 11'h000) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got {data,valid,strobe,active}=%h required 000", i, dut_vec());
      end
    end
  endtask

  task automatic test_lock();
    int rise = -1;
    int vcnt = 0;
    stim.delete();
    repeat (4) push_byte(BC);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], 1'b1);
      if (active === 1'b1 && rise < 0) rise = i + 1;
      if (valid_out !== 1'b0) vcnt++;
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL lock bit %0d: got %h required %h", i + 1, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (rise !== 32 || vcnt !== 0) begin
      n_bad++;
      $display("FAIL lock_edge: got rise=%0d valid_pulses=%0d required rise=32 valid_pulses=0", rise, vcnt);
    end
  endtask

  task automatic test_payload();
    logic [7:0] seen[$];
    int vpos[$];
    int scnt = 0;
    stim.delete();
    push_byte(8'hA5);
    push_byte(8'h3C);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], 1'b1);
      if (valid_out === 1'b1) begin seen.push_back(data_out); vpos.push_back(i); end
      if (byte_strobe === 1'b1) scnt++;
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL payload bit %0d: got %h required %h", i + 1, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (seen.size() != 2 || scnt != 2) begin
      n_bad++;
      $display("FAIL payload_count: got valid=%0d strobe=%0d required 2 and 2", seen.size(), scnt);
    end else if (seen[0] !== 8'hA5 || seen[1] !== 8'h3C || vpos[1] - vpos[0] != 8) begin
      n_bad++;
      $display("FAIL payload_data: got %h,%h gap %0d required a5,3c gap 8", seen[0], seen[1], vpos[1] - vpos[0]);
    end
  endtask

  task automatic test_idle_between();
    logic [7:0] r1 = rand_payload();
    logic [7:0] r2 = rand_payload();
    stim.delete();
    push_byte(r1);
    push_byte(BC);
    push_byte(r2);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], 1'b1);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL idle_between bit %0d: got %h required %h", i + 1, dut_vec(), mdl_vec());
      end
      if (i == 15) begin
        n_cmp++;
        if (data_out !== r1 || valid_out !== 1'b0 || byte_strobe !== 1'b1) begin
          n_bad++;
          $display("FAIL idle_hold: got data=%h valid=%b strobe=%b required data=%h valid=0 strobe=1",
                   data_out, valid_out, byte_strobe, r1);
        end
      end
    end
  endtask

  task automatic test_shifted_lock();
    int rise = -1;
    logic [7:0] exp_b[$];
    logic [7:0] seen[$];
    drive(1'b0, 1'b0);
    stim.delete();
    repeat (3) stim.push_back(1'($urandom));
    repeat (4) push_byte(BC);
    repeat (3) begin exp_b.push_back(rand_payload()); push_byte(exp_b[$]); end
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], 1'b1);
      if (active === 1'b1 && rise < 0) rise = i + 1;
      if (valid_out === 1'b1) seen.push_back(data_out);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL shifted bit %0d: got %h required %h", i + 1, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (rise !== 35 || seen.size() != 3) begin
      n_bad++;
      $display("FAIL shifted_lock: got rise=%0d bytes=%0d required rise=35 bytes=3", rise, seen.size());
    end else if (seen[0] !== exp_b[0] || seen[1] !== exp_b[1] || seen[2] !== exp_b[2]) begin
      n_bad++;
      $display("FAIL shifted_data: got %h %h %h required %h %h %h",
               seen[0], seen[1], seen[2], exp_b[0], exp_b[1], exp_b[2]);
    end
  endtask

  task automatic test_abort();
    int rise = -1;
    int vfirst = -1;
    drive(1'b0, 1'b0);
    stim.delete();
    push_byte(BC); push_byte(BC); push_byte(8'h11);
    repeat (4) push_byte(BC);
    push_byte(8'hA5);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], 1'b1);
      if (active === 1'b1 && rise < 0) rise = i + 1;
      if (valid_out === 1'b1 && vfirst < 0) vfirst = i + 1;
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL abort bit %0d: got %h required %h", i + 1, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (rise !== 56 || vfirst !== 64 || data_out !== 8'hA5) begin
      n_bad++;
      $display("FAIL abort_relock: got rise=%0d first_valid=%0d data=%h required 56 64 a5", rise, vfirst, data_out);
    end
  endtask

  task automatic test_reset_mid_active();
    int vfirst = -1;
    stim.delete();
    push_byte(8'h5A);
    for (int i = 0; i < 3; i++) drive(stim[i], 1'b1);
    drive(1'($urandom), 1'b0);
    n_cmp++;
    if (dut_vec() !== 11'h000) begin
      n_bad++;
      $display("FAIL mid_reset: got %h required 000", dut_vec());
    end
    stim.delete();
    push_byte(8'hC3);
    repeat (4) push_byte(BC);
    push_byte(8'h66);
    for (int i = 0; i < stim.size(); i++) begin
      drive(stim[i], 1'b1);
      if (valid_out === 1'b1 && vfirst < 0) vfirst = i + 1;
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL mid_reset bit %0d: got %h required %h", i + 1, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (vfirst !== 48 || data_out !== 8'h66) begin
      n_bad++;
      $display("FAIL mid_reset_relock: got first_valid=%0d data=%h required 48 66", vfirst, data_out);
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 6; round++) begin
      drive(1'($urandom), 1'b0);
      drive(1'($urandom), 1'b0);
      stim.delete();
      repeat ($urandom_range(0, 7)) stim.push_back(1'($urandom));
      repeat (4) push_byte(BC);
      for (int j = 0; j < 30; j++) begin
        if ($urandom_range(0, 1) == 0) push_byte(BC);
        else push_byte(rand_payload());
      end
      for (int i = 0; i < stim.size(); i++) begin
        // Occasional mid-stream reset exercises realignment from scratch
        drive(stim[i], ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
          n_bad++;
          $display("FAIL random r%0d bit %0d: got %h required %h", round, i + 1, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_payload();
    test_idle_between();
    test_shifted_lock();
    test_abort();
    test_reset_mid_active();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
